sparsecnn_out_encoder: RTL and testbench

Sits downstream of the SparseCNN core and consumes its single-cycle, wide `out_feature` frame: 24x24 signed 16-bit words presented on the `out_valid` pulse. It serializes that frame into a valid/ready stream of (value, row, col) triples. In sparse mode it emits only nonzero words, producing the same value/row/col sparse format the core takes on its weight inputs. It is the encode/drain end of the core's feature interface, feeding an output buffer or the next layer.

---
 rtl/sparsecnn_pkg.sv | 22 ++
 rtl/sparsecnn_out_encoder_if.sv | 31 +++
 rtl/sparsecnn_rc_counter.sv | 55 +++++
 rtl/sparsecnn_out_encoder.sv | 124 ++++++++++++
 tb/tb_sparsecnn_out_encoder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sparsecnn_pkg.sv
// Shared constants and types for the SparseCNN feature-interface blocks.
//   WORD_LENGTH : bits per signed feature word
//   OUTPUT_SIZE : output feature-map side (valid convolution of IMAGE_SIZE by KERNEL_SIZE)
//   IDX_W       : width of row/col index fields
//   CNT_W       : width of the nonzero counter
//   enc_state_t : output encoder FSM states
package sparsecnn_pkg;

  localparam int unsigned WORD_LENGTH = 16;
  localparam int unsigned IMAGE_SIZE  = 28;
  localparam int unsigned KERNEL_SIZE = 5;
  localparam int unsigned OUTPUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned IDX_W       = 8;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/sparsecnn_out_encoder_if.sv
// Frame-capture and output-stream signals of the SparseCNN output encoder.
//   in_valid/in_ready/in_feature/sparse_mode : frame side (from the core)
//   o_valid/o_ready/o_value/o_row/o_col      : (value, row, col) stream side
// master : the encoder's view; slave : the environment's view.
interface sparsecnn_out_encoder_if #(
  parameter int unsigned WORD_LENGTH = 16,
  parameter int unsigned OUT_SIZE    = 24,
  parameter int unsigned IDX_W       = 8
);

  logic                                    in_valid;
  logic                                    in_ready;
  logic [OUT_SIZE*OUT_SIZE*WORD_LENGTH-1:0] in_feature;
  logic                                    sparse_mode;
  logic                                    o_valid;
  logic                                    o_ready;
  logic [WORD_LENGTH-1:0]                  o_value;
  logic [IDX_W-1:0]                        o_row;
  logic [IDX_W-1:0]                        o_col;

  modport master (
    input  in_valid, in_feature, sparse_mode, o_ready,
    output in_ready, o_valid, o_value, o_row, o_col
  );

  modport slave (
    output in_valid, in_feature, sparse_mode, o_ready,
    input  in_ready, o_valid, o_value, o_row, o_col
  );

endinterface

// File: rtl/sparsecnn_rc_counter.sv
// Row/column raster counter over a SIZE x SIZE map.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return to (0,0); wins over enable
//   enable     : step one position; col wraps SIZE-1 -> 0 and bumps row
//   row, col   : current position
//   last       : position is (SIZE-1, SIZE-1)
module sparsecnn_rc_counter #(
  parameter int unsigned SIZE  = 24,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(SIZE - 1);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (enable) begin
      if (col_q == MaxIdx) begin
        col_d = '0;
        row_d = (row_q == MaxIdx) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == MaxIdx) && (col_q == MaxIdx);

endmodule

// File: rtl/sparsecnn_out_encoder.sv
// Captures one OUT_SIZE x OUT_SIZE frame of signed words from the SparseCNN core and
// drains it as a valid/ready stream of (value, row, col) beats in raster order. In sparse
// mode zero words are skipped (one cycle each, no handshake).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : frame capture (in_*, sparse_mode) and output stream (o_*)
//   done       : one-cycle pulse after the last word has been scanned
//   nz_count   : nonzero words in the last frame, held until the next capture
//   overrun    : sticky; a frame arrived while busy (cleared only by reset)
module sparsecnn_out_encoder #(
  parameter int unsigned WORD_LENGTH = sparsecnn_pkg::WORD_LENGTH,
  parameter int unsigned OUT_SIZE    = sparsecnn_pkg::OUTPUT_SIZE,
  parameter int unsigned IDX_W       = sparsecnn_pkg::IDX_W,
  parameter int unsigned CNT_W       = sparsecnn_pkg::CNT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  sparsecnn_out_encoder_if.master        bus,
  output logic                           done,
  output logic [CNT_W-1:0]               nz_count,
  output logic                           overrun
);

  import sparsecnn_pkg::*;

  localparam int unsigned NumWords = OUT_SIZE * OUT_SIZE;
  localparam int unsigned WordIdxW = $clog2(NumWords);

  enc_state_t state_q, state_d;

  logic [NumWords-1:0][WORD_LENGTH-1:0] frame_q;
  logic                                 mode_q;
  logic [WordIdxW-1:0]                  idx_q;
  logic [CNT_W-1:0]                     nz_count_q;
  logic                                 overrun_q;

  logic [WORD_LENGTH-1:0] word;
  logic                   nz;
  logic                   capture;
  logic                   advance;
  logic                   last;
  logic                   step;

  // Word select is by linear index; row/col come from the raster counter so no divide.
  assign word = frame_q[idx_q];
  assign nz   = |word;

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    advance     = 1'b0;
    bus.in_ready = 1'b0;
    bus.o_valid  = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          capture = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        bus.o_valid = !mode_q || nz;
        // A zero word in sparse mode is consumed without a handshake.
        advance = (bus.o_valid && bus.o_ready) || (mode_q && !nz);
        if (advance && last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign step = advance && !last;

  sparsecnn_rc_counter #(
    .SIZE  (OUT_SIZE),
    .IDX_W (IDX_W)
  ) u_rc_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (capture),
    .enable (step),
    .row    (bus.o_row),
    .col    (bus.o_col),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      mode_q     <= 1'b0;
      idx_q      <= '0;
      nz_count_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        frame_q    <= bus.in_feature;
        mode_q     <= bus.sparse_mode;
        idx_q      <= '0;
        nz_count_q <= '0;
      end else if (advance) begin
        nz_count_q <= nz_count_q + CNT_W'(nz);
        if (step) begin
          idx_q <= idx_q + 1'b1;
        end
      end
      if (bus.in_valid && !bus.in_ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.o_value = word;
  assign nz_count    = nz_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sparsecnn_out_encoder.sv
module tb_sparsecnn_out_encoder;

  localparam int unsigned WL       = 16;
  localparam int unsigned OS       = 24;
  localparam int unsigned IW       = 8;
  localparam int unsigned CW       = 16;
  localparam int unsigned NW       = OS * OS;
  localparam int unsigned FRAME_W  = NW * WL;

  typedef struct packed {
    logic [15:0] v;
    logic [7:0]  r;
    logic [7:0]  c;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          done;
  logic [CW-1:0] nz_count;
  logic          overrun;

  int n_pass  = 0;
  int n_total = 0;
  bit ovr_exp = 1'b0;

  logic [15:0] fm [NW];

  sparsecnn_out_encoder_if #(.WORD_LENGTH(WL), .OUT_SIZE(OS), .IDX_W(IW)) bus ();

  sparsecnn_out_encoder #(
    .WORD_LENGTH (WL),
    .OUT_SIZE    (OS),
    .IDX_W       (IW),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .done     (done),
    .nz_count (nz_count),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [FRAME_W-1:0] pack_frame();
    logic [FRAME_W-1:0] f;
    for (int k = 0; k < NW; k++) f[k*WL +: WL] = fm[k];
    return f;
  endfunction

  // Streams the model frame through the DUT and checks every beat against a list
  // derived directly from the frame contents. abort_beat >= 0 resets mid-scan instead.
  task automatic run_frame(input bit sparse, input int stall_at, input int stall_len,
                           input bit rand_rdy, input int ovr_cycle, input int abort_beat);
    beat_t exp_q[$];
    beat_t obs;
    logic [FRAME_W-1:0] f;
    int nz = 0;
    int cyc = 0;
    int popped = 0;
    int stalls = 0;
    int stall_left = stall_len;
    int w = 0;
    bit got_done = 1'b0;
    bit rdy;

    for (int k = 0; k < NW; k++) begin
      if (fm[k] != 16'd0) nz++;
      if (!sparse || fm[k] != 16'd0) exp_q.push_back('{v: fm[k], r: 8'(k / OS), c: 8'(k % OS)});
    end
    f = pack_frame();

    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_capture", 32'(bus.in_ready), 32'd1);
    bus.in_feature  = f;
    bus.sparse_mode = sparse;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.sparse_mode = !sparse;
    bus.in_feature  = ~f;

    while (!got_done && cyc < 3000) begin
      cyc++;
      bus.in_valid = (cyc == ovr_cycle);
      if (done) begin
        got_done = 1'b1;
        check("done_cycle", 32'(cyc), 32'(NW + 1 + stalls));
        check("valid_in_done", 32'(bus.o_valid), 32'd0);
        check("nz_count", 32'(nz_count), 32'(nz));
        bus.o_ready = 1'b1;
      end else if (bus.o_valid) begin
        if (abort_beat >= 0 && popped == abort_beat) begin
          rst_n = 1'b0;
          bus.in_valid = 1'b0;
          #1;
          check("rst_o_valid", 32'(bus.o_valid), 32'd0);
          check("rst_in_ready", 32'(bus.in_ready), 32'd1);
          check("rst_nz_count", 32'(nz_count), 32'd0);
          check("rst_overrun", 32'(overrun), 32'd0);
          for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 32'd0);
            check("rst_hold_valid", 32'(bus.o_valid), 32'd0);
          end
          rst_n = 1'b1;
          ovr_exp = 1'b0;
          return;
        end
        obs = {bus.o_value, bus.o_row, bus.o_col};
        check("beat_available", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("beat", obs, exp_q[0]);
        rdy = 1'b1;
        if (stall_at == popped && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else if (rand_rdy) begin
          rdy = ($urandom_range(3) != 0);
        end
        bus.o_ready = rdy;
        if (rdy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          popped++;
        end else begin
          stalls++;
        end
      end else begin
        bus.o_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.o_ready  = 1'b1;
    check("done_seen", 32'(got_done), 32'd1);
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("in_ready_after_done", 32'(bus.in_ready), 32'd1);
    check("nz_count_held", 32'(nz_count), 32'(nz));
    check("overrun", 32'(overrun), 32'(ovr_exp));
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < NW; k++) fm[k] = 16'(k);
  endtask

  task automatic fill_random();
    for (int k = 0; k < NW; k++) fm[k] = ($urandom_range(1) == 1) ? 16'd0 : 16'($urandom);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_feature  = '0;
    bus.sparse_mode = 1'b0;
    bus.o_ready     = 1'b1;
    rst_n           = 1'b0;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_o_valid", 32'(bus.o_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_nz_count", 32'(nz_count), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Dense ramp, always ready.
    fill_ramp();
    run_frame(1'b0, -1, 0, 1'b0, -1, -1);

    // Sparse with three nonzero words, including a negative one.
    for (int k = 0; k < NW; k++) fm[k] = 16'd0;
    fm[0]   = 16'h0008;
    fm[300] = 16'hFFF5;
    fm[575] = 16'h0001;
    run_frame(1'b1, -1, 0, 1'b0, -1, -1);

    // Sparse, all zero: no beats at all.
    for (int k = 0; k < NW; k++) fm[k] = 16'd0;
    run_frame(1'b1, -1, 0, 1'b0, -1, -1);

    // Dense ramp, ten-cycle stall at beat 5.
    fill_ramp();
    run_frame(1'b0, 5, 10, 1'b0, -1, -1);

    // Dense ramp with a frame pulse mid-scan, then a new random frame is accepted.
    fill_ramp();
    ovr_exp = 1'b1;
    run_frame(1'b0, -1, 0, 1'b0, 50, -1);
    fill_random();
    run_frame(1'b0, -1, 0, 1'b1, -1, -1);

    // Reset at beat 100, then a fresh sparse random frame from (0,0).
    fill_ramp();
    run_frame(1'b0, -1, 0, 1'b0, -1, 100);
    @(negedge clk);
    fill_random();
    run_frame(1'b1, -1, 0, 1'b1, -1, -1);

    // Extra random frames with random backpressure.
    fill_random();
    run_frame(1'b0, -1, 0, 1'b1, -1, -1);
    fill_random();
    run_frame(1'b1, -1, 0, 1'b1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
